// File: rtl/sfp_pkg.sv
// Shared encodings for the sfp accumulate/activate pipeline: activation
// modes, the leaky-ReLU shift amount and the controller state type.
package sfp_pkg;

  localparam logic [1:0] MODE_RELU     = 2'd0;
  localparam logic [1:0] MODE_PASS     = 2'd1;
  localparam logic [1:0] MODE_LEAKY    = 2'd2;
  localparam logic [1:0] MODE_PASS_ALT = 2'd3;

  // Negative slope of the leaky ReLU is 2^-LEAKY_SHIFT (floor rounding).
  localparam int LEAKY_SHIFT = 3;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/sfp_lane.sv
// One accumulator lane: saturating add of a sign-extended partial sum,
// activation on the final sum and clamp to the output width.
module sfp_lane
  import sfp_pkg::*;
#(
  parameter int BW     = 16,
  parameter int ACC_BW = 24,
  parameter int OBW    = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_acc_en,
  input  logic           i_last,
  input  logic [1:0]     i_mode,
  input  logic [BW-1:0]  i_in,
  output logic [OBW-1:0] o_out
);

  localparam logic signed [ACC_BW-1:0] ACC_MAX = {1'b0, {(ACC_BW-1){1'b1}}};
  localparam logic signed [ACC_BW-1:0] ACC_MIN = {1'b1, {(ACC_BW-1){1'b0}}};
  localparam logic signed [ACC_BW-1:0] OUT_MAX =
    {{(ACC_BW-OBW+1){1'b0}}, {(OBW-1){1'b1}}};
  localparam logic signed [ACC_BW-1:0] OUT_MIN =
    {{(ACC_BW-OBW+1){1'b1}}, {(OBW-1){1'b0}}};

  logic signed [ACC_BW-1:0] r_acc;
  logic        [OBW-1:0]    r_out;

  logic signed [ACC_BW:0]   w_in_ext;
  logic signed [ACC_BW:0]   w_acc_ext;
  logic signed [ACC_BW:0]   w_raw;
  logic                     w_ovf;
  logic signed [ACC_BW-1:0] w_sum;
  logic signed [ACC_BW-1:0] w_act;
  logic        [OBW-1:0]    w_clamp;

  // One guard bit is enough: two ACC_BW-range operands cannot overflow ACC_BW+1.
  assign w_in_ext  = {{(ACC_BW+1-BW){i_in[BW-1]}}, i_in};
  assign w_acc_ext = {r_acc[ACC_BW-1], r_acc};
  assign w_raw     = w_acc_ext + w_in_ext;
  assign w_ovf     = w_raw[ACC_BW] != w_raw[ACC_BW-1];

  always_comb begin
    w_sum = w_raw[ACC_BW-1:0];
    if (w_ovf) begin
      w_sum = w_raw[ACC_BW] ? ACC_MIN : ACC_MAX;
    end
  end

  always_comb begin
    w_act = w_sum;
    case (i_mode)
      MODE_RELU:     w_act = w_sum[ACC_BW-1] ? '0 : w_sum;
      MODE_LEAKY:    w_act = w_sum[ACC_BW-1] ? (w_sum >>> LEAKY_SHIFT) : w_sum;
      MODE_PASS,
      MODE_PASS_ALT: w_act = w_sum;
      default:       w_act = w_sum;
    endcase
  end

  always_comb begin
    w_clamp = w_act[OBW-1:0];
    if (w_act > OUT_MAX) begin
      w_clamp = OUT_MAX[OBW-1:0];
    end else if (w_act < OUT_MIN) begin
      w_clamp = OUT_MIN[OBW-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
      r_out <= '0;
    end else if (i_acc_en) begin
      if (i_last) begin
        r_acc <= '0;
        r_out <= w_clamp;
      end else begin
        r_acc <= w_sum;
      end
    end
  end

  assign o_out = r_out;

endmodule

// File: rtl/sfp_acc_pipe.sv
// Accumulates num_acc input vectors per lane, then presents one activated,
// clamped result vector and holds it until the consumer takes it.
module sfp_acc_pipe
  import sfp_pkg::*;
#(
  parameter int BW     = 16,
  parameter int ACC_BW = 24,
  parameter int OBW    = 16,
  parameter int COL    = 8,
  parameter int CW     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BW*COL-1:0]  in,
  input  logic [CW-1:0]      num_acc,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OBW*COL-1:0] out,
  output logic               dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; ready/valid are registered and never depend on the peer.
  state_t        r_state;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_n;

  logic          w_accept;
  logic [CW-1:0] w_n_new;
  logic [CW-1:0] w_n_eff;
  logic          w_last;

  assign w_accept = in_valid && r_in_ready;
  assign w_n_new  = (num_acc == '0) ? CW'(1) : num_acc;
  // The target count is taken live on the first vector, latched afterwards.
  assign w_n_eff  = (r_cnt == '0) ? w_n_new : r_n;
  assign w_last   = w_accept && (r_cnt == (w_n_eff - CW'(1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_ACC;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
      r_n         <= CW'(1);
    end else begin
      case (r_state)
        ST_ACC: begin
          if (w_accept) begin
            if (r_cnt == '0) begin
              r_n <= w_n_new;
            end
            if (w_last) begin
              r_cnt       <= '0;
              r_state     <= ST_HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        ST_HOLD: begin
          if (r_out_valid && out_ready) begin
            r_state     <= ST_ACC;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_ACC;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign dbg_state = r_state;

  for (genvar g = 0; g < COL; g++) begin : g_lane
    sfp_lane #(
      .BW     (BW),
      .ACC_BW (ACC_BW),
      .OBW    (OBW)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .i_acc_en (w_accept),
      .i_last   (w_last),
      .i_mode   (mode),
      .i_in     (in[BW*g +: BW]),
      .o_out    (out[OBW*g +: OBW])
    );
  end

endmodule

// File: tb/tb_sfp_acc_pipe.sv
// Directed bench for sfp_acc_pipe: hand-computed result vectors are queued
// and compared when each result is presented.
module tb_sfp_acc_pipe;

  localparam int BW     = 16;
  localparam int ACC_BW = 24;
  localparam int OBW    = 16;
  localparam int COL    = 8;
  localparam int CW     = 8;
  localparam int IW     = BW * COL;
  localparam int OW     = OBW * COL;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in;
  logic [CW-1:0] num_acc;
  logic [1:0]    mode;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out;
  logic          dbg_state;

  int checks = 0;
  int errors = 0;
  logic [OW-1:0] exp_q[$];

  sfp_acc_pipe #(
    .BW(BW), .ACC_BW(ACC_BW), .OBW(OBW), .COL(COL), .CW(CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in),
    .num_acc   (num_acc),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // lane 0 = v0, lane 1 = v1, remaining lanes = vr
  function automatic logic [IW-1:0] pack_i(input int v0, input int v1, input int vr);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < COL; i++) begin
      r[i*BW +: BW] = BW'((i == 0) ? v0 : (i == 1) ? v1 : vr);
    end
    return r;
  endfunction

  function automatic logic [OW-1:0] pack_o(input int v0, input int v1, input int vr);
    logic [OW-1:0] r;
    r = '0;
    for (int i = 0; i < COL; i++) begin
      r[i*OBW +: OBW] = OBW'((i == 0) ? v0 : (i == 1) ? v1 : vr);
    end
    return r;
  endfunction

  task automatic check_vec(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  // driver: called at a negedge, returns at the negedge after acceptance
  task automatic send(input logic [IW-1:0] v, input int n, input logic [1:0] m);
    int waited;
    in       = v;
    num_acc  = CW'(n);
    mode     = m;
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check_bit("send_timeout", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // scoreboard: result must already be valid (one-cycle latency), then handshake
  task automatic take_result(input string tag);
    logic [OW-1:0] exp;
    exp = exp_q.pop_front();
    check_bit({tag, "_valid"}, out_valid, 1'b1);
    check_bit({tag, "_in_ready"}, in_ready, 1'b0);
    check_vec({tag, "_out"}, out, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_bit({tag, "_released"}, out_valid, 1'b0);
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in        = '0;
    num_acc   = '0;
    mode      = 2'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_vec("reset_out", out, '0);
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_bit("reset_in_ready", in_ready, 1'b1);
    check_bit("reset_state", dbg_state, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // ReLU, N=3: lane0 5-2+4=7, lane1 -5+1+1=-3 -> 0, others 100*3
    send(pack_i(5, -5, 100), 3, 2'd0);
    send(pack_i(-2, 1, 100), 3, 2'd0);
    check_bit("relu_not_early", out_valid, 1'b0);
    send(pack_i(4, 1, 100), 3, 2'd0);
    exp_q.push_back(pack_o(7, 0, 300));
    take_result("relu");

    // leaky, N=1: -16>>>3=-2, -1>>>3=-1, -9>>>3=-2
    send(pack_i(-16, -1, -9), 1, 2'd2);
    exp_q.push_back(pack_o(-2, -1, -2));
    take_result("leaky_neg");
    send(pack_i(40, 0, 8), 1, 2'd2);
    exp_q.push_back(pack_o(40, 0, 8));
    take_result("leaky_pos");

    // saturation at output width, PASS, N=4
    for (int k = 0; k < 4; k++) send(pack_i(32767, -32768, 1), 4, 2'd1);
    exp_q.push_back(pack_o(32767, -32768, 4));
    take_result("sat");

    // mode 3 is passthrough too
    send(pack_i(-100, 5, -3), 1, 2'd3);
    exp_q.push_back(pack_o(-100, 5, -3));
    take_result("pass_alt");

    // N latched at 2 on first vector; the later num_acc=5 is ignored
    send(pack_i(10, 20, 1), 2, 2'd1);
    send(pack_i(20, 40, 2), 5, 2'd1);
    exp_q.push_back(pack_o(30, 60, 3));
    in       = pack_i(1000, 1000, 1000);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_vec("bp_out_stable", out, exp_q[0]);
      check_bit("bp_out_valid", out_valid, 1'b1);
      check_bit("bp_in_ready", in_ready, 1'b0);
    end
    take_result("bp");
    in_valid = 1'b0;
    send(pack_i(7, -7, 0), 1, 2'd1);
    exp_q.push_back(pack_o(7, -7, 0));
    take_result("bp_fresh");

    // reset in the middle of a 4-vector accumulation
    send(pack_i(50, 50, 50), 4, 2'd1);
    send(pack_i(50, 50, 50), 4, 2'd1);
    reset = 1'b0;
    #1;
    check_vec("midrst_out", out, '0);
    check_bit("midrst_out_valid", out_valid, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) send(pack_i(1, 1, 1), 4, 2'd1);
    check_bit("midrst_not_early", out_valid, 1'b0);
    send(pack_i(1, 1, 1), 4, 2'd1);
    exp_q.push_back(pack_o(4, 4, 4));
    take_result("midrst");

    // num_acc=0 behaves as 1
    send(pack_i(3, -4, 9), 0, 2'd1);
    exp_q.push_back(pack_o(3, -4, 9));
    take_result("n0_first");
    send(pack_i(-4, 6, 2), 0, 2'd1);
    exp_q.push_back(pack_o(-4, 6, 2));
    take_result("n0_second");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
